// File: rtl/aes_pkg.sv
// ============================================================================
//  aes_pkg
//  Shared AES types: inverse key-schedule FSM states and Rcon lookup.
//  Revision: 1.0
// ============================================================================
`include "aes_defines.svh"
`default_nettype none

package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
`ifdef AES128_INV_KEY_FWD_EN
        ST_EXPAND = 2'd1,
`endif
        ST_RUN    = 2'd2
    } inv_ks_state_t;

    localparam logic [3:0] c_LAST_ROUND = 4'd10;

    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] w_val;
        case (round)
            4'd1:    w_val = `AES_RCON_1;
            4'd2:    w_val = `AES_RCON_2;
            4'd3:    w_val = `AES_RCON_3;
            4'd4:    w_val = `AES_RCON_4;
            4'd5:    w_val = `AES_RCON_5;
            4'd6:    w_val = `AES_RCON_6;
            4'd7:    w_val = `AES_RCON_7;
            4'd8:    w_val = `AES_RCON_8;
            4'd9:    w_val = `AES_RCON_9;
            4'd10:   w_val = `AES_RCON_10;
            default: w_val = 8'h00;
        endcase
        return w_val;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes128_inv_key_step.sv
// ============================================================================
//  aes128_inv_key_step
//  Combinational backward AES-128 key-schedule step: round r key -> r-1 key.
//  Revision: 1.0
// ============================================================================
`include "aes_defines.svh"
`default_nettype none

module aes128_inv_key_step
    import aes_pkg::*;
(
    input  logic [`AES128_KEY_SIZE-1:0] key,
    input  logic [3:0]                  round,
    output logic [`AES128_KEY_SIZE-1:0] prev_key
);

    logic [`AES_WORD_SIZE-1:0] w_p3;
    logic [`AES_WORD_SIZE-1:0] w_rot;
    logic [`AES_WORD_SIZE-1:0] w_sub;

    // Word 3 of the previous key is recovered first; it feeds the g-function
    assign w_p3  = key[`AES_4TH_WORD] ^ key[`AES_3RD_WORD];
    assign w_rot = {w_p3[23:0], w_p3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (w_rot[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    assign prev_key[`AES_4TH_WORD] = w_p3;
    assign prev_key[`AES_3RD_WORD] = key[`AES_3RD_WORD] ^ key[`AES_2ND_WORD];
    assign prev_key[`AES_2ND_WORD] = key[`AES_2ND_WORD] ^ key[`AES_1ST_WORD];
    assign prev_key[`AES_1ST_WORD] = key[`AES_1ST_WORD] ^ w_sub ^ {rcon(round), 24'h000000};

endmodule

`default_nettype wire

// File: rtl/aes128_key_step.sv
// ============================================================================
//  aes128_key_step
//  Forward AES-128 key expansion: one round key to the next, Rcon by round.
//  Built only when AES128_INV_KEY_FWD_EN is defined.
//  Revision: 1.0
// ============================================================================
`include "aes_defines.svh"
`default_nettype none

`ifdef AES128_INV_KEY_FWD_EN
module aes128_key_step
    import aes_pkg::*;
(
    input  logic [`AES128_KEY_SIZE-1:0] i_key,
    input  logic [3:0]                  i_round,
    output logic [`AES128_KEY_SIZE-1:0] o_key
);

    logic [`AES_WORD_SIZE-1:0] w_rot;
    logic [`AES_WORD_SIZE-1:0] w_sub;
    logic [`AES_WORD_SIZE-1:0] w_t;

    assign w_rot = {i_key[23:0], i_key[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (w_rot[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    assign w_t = w_sub ^ {rcon(i_round), 24'h000000};

    assign o_key[`AES_1ST_WORD] = i_key[`AES_1ST_WORD] ^ w_t;
    assign o_key[`AES_2ND_WORD] = i_key[`AES_2ND_WORD] ^ o_key[`AES_1ST_WORD];
    assign o_key[`AES_3RD_WORD] = i_key[`AES_3RD_WORD] ^ o_key[`AES_2ND_WORD];
    assign o_key[`AES_4TH_WORD] = i_key[`AES_4TH_WORD] ^ o_key[`AES_3RD_WORD];

endmodule
`endif

`default_nettype wire

// File: rtl/aes_defines.svh
// ============================================================================
//  aes_defines.svh
//  Shared AES sizes, 32-bit word slices of a 128-bit key and Rcon constants.
//  Revision: 1.0
// ============================================================================
`default_nettype none
`ifndef AES_DEFINES_SVH
`define AES_DEFINES_SVH

`define AES128_KEY_SIZE 128
`define AES_WORD_SIZE   32

// Word 0 of the AES key schedule sits in the most significant bits
`define AES_1ST_WORD 127:96
`define AES_2ND_WORD 95:64
`define AES_3RD_WORD 63:32
`define AES_4TH_WORD 31:0

`define AES_RCON_1  8'h01
`define AES_RCON_2  8'h02
`define AES_RCON_3  8'h04
`define AES_RCON_4  8'h08
`define AES_RCON_5  8'h10
`define AES_RCON_6  8'h20
`define AES_RCON_7  8'h40
`define AES_RCON_8  8'h80
`define AES_RCON_9  8'h1b
`define AES_RCON_10 8'h36

`endif
`default_nettype wire

// File: rtl/aes_sbox.sv
// ============================================================================
//  aes_sbox
//  Forward AES S-box, pure combinational table lookup.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Entry 0x00 occupies the top byte of the table
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] w_base;

    assign w_base = 11'h7ff - {i_byte, 3'b000};
    assign o_byte = c_SBOX[w_base -: 8];

endmodule

`default_nettype wire

// File: rtl/aes128_inv_key_schedule.sv
// ============================================================================
//  aes128_inv_key_schedule
//  Streams AES-128 round keys 10 down to 0 over a valid/ready interface.
//  AES128_INV_KEY_FWD_EN: s_key is the cipher key, expanded internally first.
//  Revision: 1.0
// ============================================================================
`include "aes_defines.svh"
`default_nettype none

module aes128_inv_key_schedule
    import aes_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [`AES128_KEY_SIZE-1:0] s_key,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [`AES128_KEY_SIZE-1:0] m_key,
    output logic [3:0]                  m_round,
    output logic                        m_last
);

    inv_ks_state_t               r_state;
    inv_ks_state_t               w_state_nxt;
    logic [`AES128_KEY_SIZE-1:0] r_key;
    logic [`AES128_KEY_SIZE-1:0] w_key_nxt;
    logic [`AES128_KEY_SIZE-1:0] w_prev_key;
    logic [3:0]                  r_round;
    logic [3:0]                  w_round_nxt;

    aes128_inv_key_step u_inv_step (
        .key      (r_key),
        .round    (r_round),
        .prev_key (w_prev_key)
    );

`ifdef AES128_INV_KEY_FWD_EN
    logic [`AES128_KEY_SIZE-1:0] w_fwd_key;
    logic [3:0]                  w_fwd_round;

    assign w_fwd_round = r_round + 4'd1;

    aes128_key_step u_fwd_step (
        .i_key   (r_key),
        .i_round (w_fwd_round),
        .o_key   (w_fwd_key)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_key   <= '0;
            r_round <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_key   <= w_key_nxt;
            r_round <= w_round_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_round_nxt = r_round;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    w_key_nxt = s_key;
`ifdef AES128_INV_KEY_FWD_EN
                    w_round_nxt = 4'd0;
                    w_state_nxt = ST_EXPAND;
`else
                    w_round_nxt = c_LAST_ROUND;
                    w_state_nxt = ST_RUN;
`endif
                end
            end
`ifdef AES128_INV_KEY_FWD_EN
            ST_EXPAND: begin
                w_key_nxt   = w_fwd_key;
                w_round_nxt = w_fwd_round;
                if (w_fwd_round == c_LAST_ROUND) begin
                    w_state_nxt = ST_RUN;
                end
            end
`endif
            ST_RUN: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    // Round 0 is the final key; it stays in r_key after the transfer
                    if (r_round == 4'd0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_key_nxt   = w_prev_key;
                        w_round_nxt = r_round - 4'd1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign m_key   = r_key;
    assign m_round = r_round;
    assign m_last  = (r_state == ST_RUN) && (r_round == 4'd0);

endmodule

`default_nettype wire

// File: tb/tb_aes128_inv_key_schedule.sv
// ============================================================================
//  tb_aes128_inv_key_schedule
//  Scoreboard bench: forward-expanded reference keys vs streamed round keys.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_aes128_inv_key_schedule;

`ifdef AES128_INV_KEY_FWD_EN
    localparam int c_LAT = 11;
`else
    localparam int c_LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [127:0] s_key = '0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [127:0] m_key;
    logic [3:0]   m_round;
    logic         m_last;

    always #5 clk = ~clk;

    aes128_inv_key_schedule dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_key   (s_key),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_key   (m_key),
        .m_round (m_round),
        .m_last  (m_last)
    );

    typedef struct packed {
        logic [127:0] key;
        logic [3:0]   round;
        logic         last;
    } exp_t;

    exp_t         sb_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [7:0]   sbox_tab [256];
    logic [127:0] rk [0:10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference S-box derived from GF(2^8) inversion plus the affine map
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            sbox_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] fwd_round(input logic [127:0] k, input int r);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 1; i < r; i++) rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
        {w0, w1, w2, w3} = k;
        t = {w3[23:0], w3[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t = t ^ {rc, 24'h0};
        w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] s_key_for(input logic [127:0] k);
`ifdef AES128_INV_KEY_FWD_EN
        return k;
`else
        logic [127:0] r;
        r = k;
        for (int i = 1; i <= 10; i++) r = fwd_round(r, i);
        return r;
`endif
    endfunction

    function automatic logic [127:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Offer a cipher key's start key; expected round keys go on the scoreboard
    task automatic start_key(input logic [127:0] k, input logic hold,
                             input logic [127:0] hold_key, input logic spec_vec,
                             output int waited);
        int base;
        rk[0] = k;
        for (int r = 1; r <= 10; r++) rk[r] = fwd_round(rk[r-1], r);
        base = sb_q.size();
        for (int r = 10; r >= 0; r--) sb_q.push_back({rk[r], 4'(r), r == 0});
        if (spec_vec) begin
            sb_q[base].key      = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
            sb_q[base + 1].key  = 128'hac7766f319fadc2128d12941575c006e;
            sb_q[base + 9].key  = 128'ha0fafe1788542cb123a339392a6c7605;
            sb_q[base + 10].key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        end
        s_key   = s_key_for(k);
        s_valid = 1'b1;
        waited  = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!s_ready && waited < 50);
        if (!s_ready) begin
            errors++;
            $display("FAIL accept_timeout: s_ready stayed %b", s_ready);
        end
        @(posedge clk); #1;
        s_valid = hold;
        s_key   = hold ? hold_key : rand_key();
    endtask

    task automatic drain(input logic bp, input int stop);
        int cyc;
        cyc = 0;
        while (sb_q.size() > stop && cyc < 400) begin
            m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        if (sb_q.size() > stop) begin
            errors++;
            $display("FAIL drain_timeout: %0d pending, required %0d", sb_q.size(), stop);
            sb_q.delete();
        end
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        chk({name, "_s_ready"}, s_ready, 1'b1);
        chk({name, "_m_valid"}, m_valid, 1'b0);
    endtask

    // Monitor: scoreboard pops, stall stability, first-output latency
    logic         prev_stall = 1'b0;
    logic [127:0] prev_key = '0;
    logic [3:0]   prev_round = '0;
    int           lat_cnt = -1;
    exp_t         e;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            lat_cnt    = -1;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1'b1);
                chk("stall_key", m_key, prev_key);
                chk("stall_round", m_round, prev_round);
            end
            if (lat_cnt >= 0) begin
                lat_cnt++;
                if (m_valid) begin
                    chk("first_valid_latency", lat_cnt, c_LAT);
                    lat_cnt = -1;
                end else if (lat_cnt > 20) begin
                    chk("first_valid_latency", lat_cnt, c_LAT);
                    lat_cnt = -1;
                end
            end
            if (m_valid) chk("s_ready_during_run", s_ready, 1'b0);
            if (m_valid && m_ready) begin
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: round %0d key %h, none expected", m_round, m_key);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("m_key_r%0d", e.round), m_key, e.key);
                    chk("m_round", m_round, e.round);
                    chk("m_last", m_last, e.last);
                end
            end
            if (s_valid && s_ready) lat_cnt = 0;
            prev_stall = m_valid && !m_ready;
            prev_key   = m_key;
            prev_round = m_round;
        end
    end

    int           waited;
    logic [127:0] k1, k2;

    initial begin
        build_sbox();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_m_valid", m_valid, 1'b0);
        chk("reset_s_ready", s_ready, 1'b1);
        chk("reset_m_last", m_last, 1'b0);
        chk("reset_m_round", m_round, 4'd0);
        chk("reset_m_key", m_key, 128'h0);
        @(posedge clk); #1;

        // Known-answer vector, no backpressure
        start_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, '0, 1'b1, waited);
        drain(1'b0, 0);
        s_valid = 1'b0;
        check_idle("after_kat");
        @(posedge clk); #1;

        // Random keys under random backpressure
        for (int n = 0; n < 3; n++) begin
            start_key(rand_key(), 1'b0, '0, 1'b0, waited);
            drain(1'b1, 0);
        end

        // s_valid held with a different key during RUN must not reload
        start_key(rand_key(), 1'b1, rand_key(), 1'b0, waited);
        drain(1'b1, 0);
        s_valid = 1'b0;
        check_idle("after_hold");
        @(posedge clk); #1;

        // Back-to-back: second key accepted right after the round-0 transfer
        k1 = rand_key();
        k2 = rand_key();
        start_key(k1, 1'b1, s_key_for(k2), 1'b0, waited);
        drain(1'b1, 0);
        start_key(k2, 1'b0, '0, 1'b0, waited);
        chk("b2b_accept_cycle", waited, 1);
        drain(1'b0, 0);
        @(posedge clk); #1;

        // Reset after the round-5 transfer aborts the sequence
        start_key(rand_key(), 1'b0, '0, 1'b0, waited);
        drain(1'b1, 5);
        rst     = 1'b1;
        m_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        check_idle("after_rst");
        @(posedge clk); #1;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start_key(rand_key(), 1'b0, '0, 1'b0, waited);
        drain(1'b0, 0);
        check_idle("after_restart");

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes128_inv_key_schedule.md
AES128_INV_KEY_SCHEDULE -- requirements
Module: aes128_inv_key_schedule

Interface
REQ-001 SHALL have no parameters; all sizes come from the shared AES defines (AES128_KEY_SIZE=128, AES_WORD_SIZE=32).
REQ-002 SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 s_valid  input  1  input key offered.
REQ-006 s_ready  output  1  block can accept a key.
REQ-007 s_key  input  128  start key, word order per AES_1ST..4TH_WORD.
REQ-008 m_valid  output  1  m_key/m_round valid.
REQ-009 m_ready  input  1  consumer accepts the current round key.
REQ-010 m_key  output  128  current round key.
REQ-011 m_round  output  4  round index of m_key, 10 down to 0.
REQ-012 m_last  output  1  high with m_valid when m_round==0.

Function
REQ-013 FSM states: IDLE, EXPAND (present only with the macro), RUN.
REQ-014 IDLE: s_ready=1, m_valid=0; s_valid&s_ready loads s_key into key_q.
REQ-015 Without the macro: accept -> RUN, round_q=10; m_valid=1 on the next cycle (latency 1).
REQ-016 RUN: m_valid=1 and m_key=key_q held stable until m_valid&m_ready; s_ready=0 and s_valid is ignored.
REQ-017 Backward step from round r (r=10..1): p3=k3^k2, p2=k2^k1, p1=k1^k0, p0=k0^SubWord(RotWord(p3))^Rcon(r).
REQ-018 RotWord and SubWord SHALL match the forward schedule exactly, including the byte rotation direction.
REQ-019 On transfer with round_q>0: key_q <= previous round key, round_q <= round_q-1.
REQ-020 On transfer with round_q==0 (m_last=1): -> IDLE, s_ready=1 on the following cycle; key_q is retained.
REQ-021 m_ready low: hold all state indefinitely with no output change.
REQ-022 Exactly 11 transfers per accepted key, rounds 10,9,...,0 in order.
REQ-023 Round counter SHALL never wrap below 0 or exceed 10.

Reset
REQ-024 rst SHALL force IDLE, round_q=0, key_q=0, m_valid=0, m_last=0, s_ready=1 on the next edge.
REQ-025 rst asserted mid-operation (EXPAND or RUN) SHALL abort the sequence; no further outputs follow.
REQ-026 rst SHALL take priority over every handshake event in the same cycle.

Configuration
REQ-027 Macro AES128_INV_KEY_FWD_EN SHALL select the meaning of s_key.
REQ-028 Without the macro: s_key is the round-10 key; the EXPAND state and its logic are absent.
REQ-029 With the macro: s_key is the cipher key (round 0); accept -> EXPAND.
REQ-030 EXPAND: 10 cycles of forward expansion with Rcon(1..10), one round per cycle, then -> RUN at round 10.
REQ-031 With the macro, the first m_valid SHALL appear 11 cycles after accept; s_ready=0 throughout EXPAND.

Structure
REQ-032 Rcon values and word slice macros SHALL come from the shared aes_defines.svh.
REQ-033 The FSM state enum typedef SHALL live in the shared package aes_pkg.
REQ-034 Combinational backward step SHALL be the sub-module aes128_inv_key_step (inputs key, round; output prev_key).
REQ-035 aes128_inv_key_step SHALL instantiate four aes_sbox instances.
REQ-036 The forward step (macro build only) SHALL reuse the existing forward key-expansion logic, selecting Rcon by round_q.

Verification
REQ-037 Macro off, s_key=d014f9a8c9ee2589e13f0cc8b6630ca6, m_ready=1 -> the following transfers occur:
- round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6
- round 9 = ac7766f319fadc2128d12941575c006e
- round 1 = a0fafe1788542cb123a339392a6c7605
- round 0 = 2b7e151628aed2a6abf7158809cf4f3c, with m_last=1
REQ-038 Macro on, s_key=2b7e151628aed2a6abf7158809cf4f3c -> first m_valid 11 cycles after accept, with m_key=d014f9a8...0ca6; the same 11-key sequence follows.
REQ-039 Random m_ready backpressure -> m_key/m_round stable while stalled; exactly 11 transfers; no key skipped or repeated.
REQ-040 s_valid held high during RUN -> no second load; s_ready=0 until the cycle after the round-0 transfer.
REQ-041 rst pulsed after the round-5 transfer -> next cycle m_valid=0, s_ready=1; a fresh key then restarts the sequence at round 10.
REQ-042 Back-to-back keys -> second key accepted the cycle after the round-0 transfer; its first output is correct.
